// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by the fetch and memory stages.
// Data has priority; a starvation counter gives fetch a turn after MAX_WAIT
// consecutive denials. Read responses are steered back to their owner by a
// fixed-latency tag pipeline of MEM_LAT stages.
module mem_arbiter #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch requester
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_width,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  input  logic [31:0] mem_rdata,
  // hazard unit
  output logic        stall_f,
  output logic        stall_m,
  output logic [15:0] conflict_cnt
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]         starve_q, starve_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;   // tag valid per stage
  logic [MEM_LAT-1:0] own_q, own_d;   // tag owner per stage, 1 = fetch
  logic [2:0]         pend_q, pend_d; // loads granted but not yet returned
  logic [15:0]        cnt_q, cnt_d;
  logic               f_win, d_win, rd_issue, ld_gnt;

  // Arbitration and memory command; grants are suppressed while in reset.
  always_comb begin
    f_win     = ~rst & f_req & (~d_req | (starve_q == MAX_W));
    d_win     = ~rst & d_req & ~f_win;
    f_gnt     = f_win;
    d_gnt     = d_win;
    mem_en    = f_win | d_win;
    mem_we    = d_win & d_we;
    mem_addr  = f_win ? f_addr : d_addr;
    mem_width = f_win ? 3'b010 : d_width;
    mem_wdata = d_wdata;
    rd_issue  = mem_en & ~mem_we;
    ld_gnt    = d_win & ~d_we;
  end

  // Response steering, stalls and next-state for all counters and tags.
  always_comb begin
    f_rvalid = ~rst & vld_q[MEM_LAT-1] & own_q[MEM_LAT-1];
    d_rvalid = ~rst & vld_q[MEM_LAT-1] & ~own_q[MEM_LAT-1];
    f_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
    stall_f  = ~rst & f_req & ~f_gnt;
    stall_m  = ~rst & ((d_req & ~d_gnt) | ((pend_q != 3'd0) & ~d_rvalid));

    starve_d = starve_q;
    if (f_gnt || !f_req)       starve_d = 4'd0;
    else if (starve_q != MAX_W) starve_d = starve_q + 4'd1;

    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = rd_issue;
    own_d[0] = f_win;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end

    pend_d = pend_q;
    case ({ld_gnt, d_rvalid})
      2'b10:   pend_d = pend_q + 3'd1;
      2'b01:   pend_d = pend_q - 3'd1;
      default: pend_d = pend_q;
    endcase

    cnt_d = cnt_q;
    if (f_req && d_req && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  assign conflict_cnt = cnt_q;

  // State registers; reset discards all in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      vld_q    <= '0;
      own_q    <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Three instances (MEM_LAT = 1, 2, 3) share
// all inputs; each test checks the instance whose latency it targets.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0]  d_width;

  logic [2:0]        f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, stall_f, stall_m;
  logic [2:0][31:0]  f_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0][2:0]   mem_width;
  logic [2:0][15:0]  conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.MEM_LAT(g+1), .MAX_WAIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt[g]),
      .f_rvalid(f_rvalid[g]), .f_rdata(f_rdata[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_width(d_width), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]),
      .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_width(mem_width[g]),
      .mem_rdata(mem_rdata),
      .stall_f(stall_f[g]), .stall_m(stall_m[g]),
      .conflict_cnt(conflict_cnt[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change just after the rising edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; d_width = 3'b010; mem_rdata = '0;

    // reset: everything quiet even with both requesting
    smp();
    chk("rst_fgnt",   f_gnt[0],    1'b0);
    chk("rst_dgnt",   d_gnt[0],    1'b0);
    chk("rst_memen",  mem_en[0],   1'b0);
    chk("rst_stallf", stall_f[0],  1'b0);
    chk("rst_stallm", stall_m[0],  1'b0);
    cyc(); cyc();
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
    smp();
    chk("rst_cnt",    conflict_cnt[0], 16'd0);
    chk("rst_rvalid", {29'd0, f_rvalid}, 32'd0);

    // fetch only, MEM_LAT = 1
    f_req = 1'b1; f_addr = 32'h100; mem_rdata = 32'h1111_2222;
    smp();
    chk("fo_gnt",   f_gnt[0],     1'b1);
    chk("fo_addr",  mem_addr[0],  32'h100);
    chk("fo_we",    mem_we[0],    1'b0);
    chk("fo_width", mem_width[0], 3'b010);
    chk("fo_stall", stall_f[0],   1'b0);
    cyc();
    f_req = 1'b0;
    smp();
    chk("fo_rvld",  f_rvalid[0],  1'b1);
    chk("fo_rdata", f_rdata[0],   32'h1111_2222);
    chk("fo_drvld", d_rvalid[0],  1'b0);
    chk("fo_stall2", stall_f[0],  1'b0);
    cyc();

    // conflict: store wins over fetch
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
    d_wdata = 32'hDEAD_BEEF; d_width = 3'b001;
    smp();
    chk("cf_dgnt",  d_gnt[0],     1'b1);
    chk("cf_fgnt",  f_gnt[0],     1'b0);
    chk("cf_we",    mem_we[0],    1'b1);
    chk("cf_addr",  mem_addr[0],  32'h200);
    chk("cf_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk("cf_width", mem_width[0], 3'b001);
    chk("cf_stall", stall_f[0],   1'b1);
    cyc();
    d_req = 1'b0;
    smp();
    chk("cf_cnt",   conflict_cnt[0], 16'd1);
    chk("cf_fgnt2", f_gnt[0],     1'b1);
    chk("cf_addr2", mem_addr[0],  32'h100);
    cyc();
    f_req = 1'b0;

    // starvation from a clean reset: d,d,d,d,f,d
    rst = 1'b1; cyc(); rst = 1'b0;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk($sformatf("sv_d%0d", i), d_gnt[0], (i != 4));
      chk($sformatf("sv_f%0d", i), f_gnt[0], (i == 4));
      cyc();
    end
    f_req = 1'b0; d_req = 1'b0;
    smp();
    chk("sv_cnt", conflict_cnt[0], 16'd6);
    cyc();

    // single load, MEM_LAT = 3
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_width = 3'b010;
    smp();
    chk("ld_gnt",  d_gnt[2],   1'b1);
    chk("ld_sm0",  stall_m[2], 1'b0);
    cyc(); d_req = 1'b0;
    smp();
    chk("ld_sm1",  stall_m[2], 1'b1);
    chk("ld_rv1",  d_rvalid[2], 1'b0);
    cyc();
    smp();
    chk("ld_sm2",  stall_m[2], 1'b1);
    cyc(); mem_rdata = 32'hCAFE_0003;
    smp();
    chk("ld_rv3",  d_rvalid[2], 1'b1);
    chk("ld_rd3",  d_rdata[2],  32'hCAFE_0003);
    chk("ld_sm3",  stall_m[2],  1'b0);
    chk("ld_frv3", f_rvalid[2], 1'b0);
    cyc();
    smp();
    chk("ld_rv4",  d_rvalid[2], 1'b0);
    cyc();

    // interleaved reads, MEM_LAT = 2: d@0, f@1, d@2
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    smp();
    chk("il_dg0", d_gnt[1], 1'b1);
    cyc(); d_req = 1'b0; f_req = 1'b1; f_addr = 32'h400;
    smp();
    chk("il_fg1", f_gnt[1], 1'b1);
    chk("il_l1rv", d_rvalid[0], 1'b1);
    cyc(); f_req = 1'b0; d_req = 1'b1; mem_rdata = 32'h0000_00A2;
    smp();
    chk("il_drv2", d_rvalid[1], 1'b1);
    chk("il_frv2", f_rvalid[1], 1'b0);
    chk("il_drd2", d_rdata[1],  32'hA2);
    chk("il_sm2",  stall_m[1],  1'b0);
    cyc(); d_req = 1'b0; mem_rdata = 32'h0000_00B3;
    smp();
    chk("il_frv3", f_rvalid[1], 1'b1);
    chk("il_drv3", d_rvalid[1], 1'b0);
    chk("il_frd3", f_rdata[1],  32'hB3);
    chk("il_sm3",  stall_m[1],  1'b1);
    cyc(); mem_rdata = 32'h0000_00C4;
    smp();
    chk("il_drv4", d_rvalid[1], 1'b1);
    chk("il_frv4", f_rvalid[1], 1'b0);
    chk("il_sm4",  stall_m[1],  1'b0);
    cyc();
    smp();
    chk("il_rv5",  {f_rvalid[1], d_rvalid[1]}, 2'b00);
    chk("il_sm5",  stall_m[1],  1'b0);
    cyc();

    // reset mid-flight, MEM_LAT = 3
    d_req = 1'b1; d_we = 1'b0;
    smp();
    chk("rm_gnt", d_gnt[2], 1'b1);
    cyc(); d_req = 1'b0;
    smp();
    chk("rm_sm1", stall_m[2], 1'b1);
    cyc(); rst = 1'b1; f_req = 1'b1; d_req = 1'b1;
    smp();
    chk("rm_outs", {f_gnt[2], d_gnt[2], mem_en[2], mem_we[2], stall_f[2],
                    stall_m[2], f_rvalid[2], d_rvalid[2]}, 8'h00);
    cyc(); rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("rm_rv%0d", i), d_rvalid[2], 1'b0);
      chk($sformatf("rm_sm%0d", i), stall_m[2],  1'b0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the CPU fetch stage and the memory stage. Grants at most one access per cycle. Data accesses have priority, and a starvation counter bounds how long fetch can wait. In-order read responses are returned to each requester through a fixed-latency tag pipeline. The block drives per-requester stall outputs that feed the hazard unit.

## Interface
- MEM_LAT, 1: memory read latency in cycles; legal range 1..4.
- MAX_WAIT, 4: consecutive denied fetch cycles before fetch takes priority; legal range 1..15.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch requests a read.
- f_addr  in  32  fetch address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid this cycle.
- f_rdata  out  32  fetch read data, qualified by f_rvalid.
- d_req  in  1  data stage requests access.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_width  in  3  access width code, passed through unchanged.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid this cycle.
- d_rdata  out  32  load data, qualified by d_rvalid.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_width  out  3  memory width code.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the read's mem_en.
- stall_f  out  1  fetch must hold.
- stall_m  out  1  memory stage must hold.
- conflict_cnt  out  16  saturating count of cycles in which both requesters requested.

## Operation
- **Arbitration (combinational, same cycle):**
  - Only one requester: that requester is granted.
  - Both requesting: d wins unless starve_cnt == MAX_WAIT, in which case f wins.
  - Neither requesting: mem_en = 0 and both grants are 0.
- **Memory command:**
  - mem_* is driven from the winner.
  - Fetch wins: mem_we = 0 and mem_width = 3'b010 (word).
  - Data wins: mem_we = d_we.
  - mem_wdata = d_wdata regardless of winner.
- **starve_cnt (4-bit):**
  - Cleared when f_gnt = 1 or f_req = 0.
  - Otherwise increments, saturating at MAX_WAIT.
- **Tag pipeline (MEM_LAT stages of {valid, owner}):**
  - Stage 0 is loaded with valid = granted & ~mem_we and owner = f/d.
  - Entries shift each cycle.
  - The last stage drives f_rvalid or d_rvalid. f_rdata = d_rdata = mem_rdata.
- **d_rd_pend counter (3-bit):** number of granted loads not yet returned. +1 on a load grant, -1 on d_rvalid; both in the same cycle leaves it unchanged.
- **Stalls:**
  - stall_f = f_req & ~f_gnt.
  - stall_m = (d_req & ~d_gnt) | (d_rd_pend != 0 & ~d_rvalid).
- **Requester handshake:**
  - Hold req and payload stable until gnt.
  - Withdrawing req before gnt is legal (flush); no access occurs.
  - Back-to-back requests are legal; responses return in grant order.
- **conflict_cnt:** increments when f_req & d_req; saturates at 16'hFFFF.

## Timing
- **Grant:** same cycle as request; zero added latency.
- **Read response:** rvalid asserts exactly MEM_LAT cycles after the cycle of the read grant.
- **Write:** completes at the rising edge that ends its grant cycle; no response.
- **Reset:**
  - All tag stages, starve_cnt, d_rd_pend and conflict_cnt are cleared.
  - Reset values: f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, stall_f, stall_m = 0; conflict_cnt = 0.
  - While rst = 1 the grant logic is forced to 0 and mem_en = 0.
- **Reset mid-operation:** in-flight reads are discarded. No rvalid appears after reset for any read granted before reset.
- **Simultaneous events:**
  - Load grant and d_rvalid in one cycle: d_rd_pend unchanged, stall_m = 0 that cycle.
  - starve_cnt reaching MAX_WAIT while d_req drops: fetch is granted by the normal single-requester rule.
- **Saturation:** starve_cnt holds at MAX_WAIT until fetch is granted; conflict_cnt holds at 16'hFFFF.

## Test plan
- **Fetch only:** f_req = 1, f_addr = 0x100, MEM_LAT = 1.
  - Required: f_gnt = 1 and mem_addr = 0x100 in the same cycle.
  - Required: f_rvalid = 1 with f_rdata = mem_rdata one cycle later; stall_f = 0 throughout.
- **Conflict, data priority:** f_req = d_req = 1 with a store to 0x200, data 0xDEADBEEF.
  - Required: d_gnt = 1, mem_we = 1, f_gnt = 0, stall_f = 1, conflict_cnt = 1.
  - Required next cycle, d_req = 0: f_gnt = 1.
- **Starvation:** MAX_WAIT = 4; f_req and d_req held high continuously.
  - Required: d wins cycles 0–3 and f wins cycle 4.
  - Required: starve_cnt returns to 0 and d wins cycle 5; conflict_cnt = 6 after 6 cycles.
- **Load stall:** MEM_LAT = 3; a single load is granted at cycle 0.
  - Required: stall_m = 1 in cycles 1–2.
  - Required: d_rvalid = 1 and stall_m = 0 in cycle 3.
- **Interleaved reads:** MEM_LAT = 2; d load granted at cycle 0, f read at cycle 1, d load at cycle 2.
  - Required: d_rvalid at cycles 2 and 4, f_rvalid at cycle 3, with no cross-delivery.
- **Reset mid-flight:** MEM_LAT = 3; a load is granted, then rst = 1 for one cycle two cycles later.
  - Required: no d_rvalid at any later cycle; all outputs are 0 during reset.
  - Required: d_rd_pend = 0 and stall_m = 0 after reset.
